// File: rtl/udma_clkgen_param.sv
// rtl/udma_clkgen_param.sv - parametrised integer clock divider with handshake reconfiguration
module udma_clkgen_param #(
  parameter int DIV_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             dft_test_mode_i,
  input  logic             dft_cg_enable_i,
  input  logic             clock_enable_i,
  input  logic [DIV_W-1:0] clk_div_data_i,
  input  logic             clk_div_valid_i,
  output logic             clk_div_ack_o,
  output logic [DIV_W-1:0] clk_div_o,
  output logic             busy_o,
  output logic             clk_o
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, STOP, SWITCH, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             sync0_q, sync1_q, sync2_q;
  logic             req;
  logic [DIV_W-1:0] reg_req_q;
  logic             pending_q;
  logic             bypass_q;
  logic [DIV_W-1:0] cnt_q, cnt_next;
  logic [DIV_W:0]   half;
  logic             div_q;
  logic             do_switch;
  logic             gate_en;
  logic             clk_mux, clk_dft, en_latch;

  assign clk_div_ack_o = sync1_q;
  assign req           = sync1_q & ~sync2_q;
  assign busy_o        = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      reg_req_q <= '0;
      pending_q <= 1'b0;
      state_q   <= IDLE;
      settle_q  <= '0;
    end else begin
      sync0_q  <= clk_div_valid_i;
      sync1_q  <= sync0_q;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      settle_q <= settle_d;
      if (req) reg_req_q <= clk_div_data_i;
      // a request landing outside IDLE is replayed once the FSM gets back there
      if (state_q == IDLE) pending_q <= 1'b0;
      else if (req)        pending_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    gate_en   = 1'b0;
    do_switch = 1'b0;
    case (state_q)
      IDLE: begin
        gate_en = clock_enable_i;
        if (req || pending_q) begin
          state_d  = STOP;
          settle_d = SETTLE_LOAD;
        end
      end
      STOP: begin
        if (settle_q == '0) begin
          state_d   = SWITCH;
          do_switch = 1'b1;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      SWITCH: begin
        state_d  = RELEASE;
        settle_d = SETTLE_LOAD;
      end
      RELEASE: begin
        if (settle_q == '0) state_d = IDLE;
        else                settle_d = settle_q - SW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign half = ({1'b0, clk_div_o} + (DIV_W+1)'(1)) >> 1;

  always_comb begin
    cnt_next = cnt_q + DIV_W'(1);
    if (cnt_q == clk_div_o - DIV_W'(1)) cnt_next = '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clk_div_o <= '0;
      bypass_q  <= 1'b1;
      cnt_q     <= '0;
      div_q     <= 1'b0;
    end else if (do_switch) begin
      // new divider starts its first high phase right at the switch edge
      clk_div_o <= reg_req_q;
      bypass_q  <= (reg_req_q <= DIV_W'(1));
      cnt_q     <= '0;
      div_q     <= (reg_req_q > DIV_W'(1));
    end else if (bypass_q) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      div_q <= ({1'b0, cnt_next} < half);
    end
  end

  assign clk_mux = bypass_q ? clk_i : div_q;
  assign clk_dft = dft_test_mode_i ? clk_i : clk_mux;

  // enable only moves while the gated clock is low, so clk_o never glitches
  always_latch begin
    if (!clk_dft) en_latch = gate_en | dft_cg_enable_i;
  end

  assign clk_o = clk_dft & en_latch;

endmodule

// File: tb/tb_udma_clkgen_param.sv
// tb/tb_udma_clkgen_param.sv - self-checking bench for udma_clkgen_param
module tb_udma_clkgen_param;
  localparam int DIV_W  = 16;
  localparam int SETTLE = 2;

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic             dft_test_mode_i = 1'b0;
  logic             dft_cg_enable_i = 1'b0;
  logic             clock_enable_i = 1'b1;
  logic [DIV_W-1:0] clk_div_data_i = '0;
  logic             clk_div_valid_i = 1'b0;
  logic             clk_div_ack_o;
  logic [DIV_W-1:0] clk_div_o;
  logic             busy_o;
  logic             clk_o;

  int n_checks = 0;
  int n_fail = 0;

  udma_clkgen_param #(.DIV_W(DIV_W), .SETTLE(SETTLE)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .dft_test_mode_i(dft_test_mode_i),
    .dft_cg_enable_i(dft_cg_enable_i), .clock_enable_i(clock_enable_i),
    .clk_div_data_i(clk_div_data_i), .clk_div_valid_i(clk_div_valid_i),
    .clk_div_ack_o(clk_div_ack_o), .clk_div_o(clk_div_o), .busy_o(busy_o), .clk_o(clk_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int exp_high(input int n); return (n + 1) / 2; endfunction
  function automatic int exp_low(input int n);  return n / 2;       endfunction

  task automatic step();  @(posedge clk_i); #1; endtask
  task automatic nstep(); @(negedge clk_i); #1; endtask

  task automatic handshake(input logic [DIV_W-1:0] v);
    int i;
    clk_div_data_i = v;
    clk_div_valid_i = 1'b1;
    i = 0;
    while (clk_div_ack_o !== 1'b1 && i < 10) begin step(); i++; end
    n_checks++;
    if (clk_div_ack_o !== 1'b1) begin n_fail++; $display("FAIL hs_ack_rise: ack=%b required 1", clk_div_ack_o); end
    clk_div_valid_i = 1'b0;
    i = 0;
    while (clk_div_ack_o !== 1'b0 && i < 10) begin step(); i++; end
    n_checks++;
    if (clk_div_ack_o !== 1'b0) begin n_fail++; $display("FAIL hs_ack_fall: ack=%b required 0", clk_div_ack_o); end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy_o !== 1'b0 && i < 60) begin step(); i++; end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wait_idle: busy=%b required 0", busy_o); end
  endtask

  task automatic measure(input int n, input string tag);
    int i, h, l;
    logic prev;
    i = 0;
    prev = clk_o;
    step();
    while (!(prev === 1'b0 && clk_o === 1'b1) && i < 2 * n + 20) begin prev = clk_o; step(); i++; end
    h = 0;
    while (clk_o === 1'b1 && h < n + 5) begin h++; step(); end
    l = 0;
    while (clk_o === 1'b0 && l < n + 5) begin l++; step(); end
    n_checks++;
    if (h != exp_high(n)) begin n_fail++; $display("FAIL %s_high: got %0d cycles required %0d", tag, h, exp_high(n)); end
    n_checks++;
    if (l != exp_low(n)) begin n_fail++; $display("FAIL %s_low: got %0d cycles required %0d", tag, l, exp_low(n)); end
  endtask

  task automatic check_follows_clk(input string tag);
    int bad;
    bad = 0;
    repeat (4) begin
      step();
      if (clk_o !== 1'b1) bad++;
      nstep();
      if (clk_o !== 1'b0) bad++;
    end
    step();
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s: %0d samples differ from clk_i, required 0", tag, bad); end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    clock_enable_i = 1'b1;
    repeat (3) step();
    n_checks++;
    if (clk_div_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0", clk_div_ack_o); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    n_checks++;
    if (clk_div_o !== '0) begin n_fail++; $display("FAIL reset_div: got %0d required 0", clk_div_o); end
    rstn_i = 1'b1;
    check_follows_clk("reset_bypass");
  endtask

  task automatic test_div4();
    int i, busy_len, gate_bad;
    logic [DIV_W-1:0] div_before, div_at;
    clk_div_data_i = 16'd4;
    clk_div_valid_i = 1'b1;
    step();
    n_checks++;
    if (clk_div_ack_o !== 1'b0) begin n_fail++; $display("FAIL div4_ack_early: got %b required 0", clk_div_ack_o); end
    step();
    n_checks++;
    if (clk_div_ack_o !== 1'b1) begin n_fail++; $display("FAIL div4_ack_latency: got %b required 1", clk_div_ack_o); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL div4_busy_early: got %b required 0", busy_o); end
    step();
    clk_div_valid_i = 1'b0;
    busy_len = 0; gate_bad = 0; div_before = '1; div_at = '1; i = 0;
    while (busy_o === 1'b1 && i < 30) begin
      if (i == SETTLE - 1) div_before = clk_div_o;
      if (i == SETTLE) div_at = clk_div_o;
      if (i >= 1 && clk_o !== 1'b0) gate_bad++;
      busy_len++;
      step();
      i++;
    end
    n_checks++;
    if (busy_len != 2 * SETTLE + 1) begin n_fail++; $display("FAIL div4_busy_len: got %0d required %0d", busy_len, 2 * SETTLE + 1); end
    n_checks++;
    if (div_before !== '0) begin n_fail++; $display("FAIL div4_div_before: got %0d required 0", div_before); end
    n_checks++;
    if (div_at !== 16'd4) begin n_fail++; $display("FAIL div4_div_update: got %0d required 4", div_at); end
    n_checks++;
    if (gate_bad != 0) begin n_fail++; $display("FAIL div4_gate_closed: %0d high samples required 0", gate_bad); end
    measure(4, "div4");
  endtask

  task automatic test_div5_extremes();
    int i;
    handshake(16'd5);
    wait_idle();
    n_checks++;
    if (clk_div_o !== 16'd5) begin n_fail++; $display("FAIL div5_value: got %0d required 5", clk_div_o); end
    measure(5, "div5");
    handshake(16'd1);
    wait_idle();
    n_checks++;
    if (clk_div_o !== 16'd1) begin n_fail++; $display("FAIL div1_value: got %0d required 1", clk_div_o); end
    check_follows_clk("div1_bypass");
    handshake(16'hFFFF);
    wait_idle();
    i = 0;
    while (clk_o !== 1'b1 && i < 65535 + 10) begin step(); i++; end
    n_checks++;
    if (i != 65535 - SETTLE - 1) begin n_fail++; $display("FAIL divffff_first_rise: got %0d cycles required %0d", i, 65535 - SETTLE - 1); end
  endtask

  task automatic test_queued();
    logic bq[$];
    logic [DIV_W-1:0] dq[$];
    logic [DIV_W-1:0] vals[$];
    logic [DIV_W-1:0] prev;
    int first, last, gap;
    prev = clk_div_o;
    fork
      begin handshake(16'd6); handshake(16'd3); end
      begin for (int i = 0; i < 40; i++) begin step(); bq.push_back(busy_o); dq.push_back(clk_div_o); end end
    join
    first = -1; last = -1; gap = 0;
    for (int i = 0; i < bq.size(); i++) if (bq[i] === 1'b1) begin if (first < 0) first = i; last = i; end
    for (int i = first; i <= last && first >= 0; i++) if (bq[i] !== 1'b1) gap++;
    for (int i = 0; i < dq.size(); i++) if (dq[i] !== prev) begin vals.push_back(dq[i]); prev = dq[i]; end
    n_checks++;
    if (gap != 1) begin n_fail++; $display("FAIL queued_busy_gap: got %0d idle cycles required 1", gap); end
    n_checks++;
    if (vals.size() != 2 || vals[0] !== 16'd6 || vals[1] !== 16'd3) begin
      n_fail++; $display("FAIL queued_sequence: got %0d values (first %0d) required 6 then 3", vals.size(), (vals.size() > 0) ? vals[0] : '0);
    end
    wait_idle();
    measure(3, "queued_div3");
  endtask

  task automatic test_gating();
    int bad;
    clock_enable_i = 1'b0;
    repeat (4) step();
    bad = 0;
    repeat (12) begin if (clk_o !== 1'b0) bad++; step(); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL gate_off: %0d high samples required 0", bad); end
    dft_cg_enable_i = 1'b1;
    measure(3, "dft_cg");
    dft_cg_enable_i = 1'b0;
    clock_enable_i = 1'b1;
    handshake(16'd8);
    wait_idle();
    dft_test_mode_i = 1'b1;
    step();
    check_follows_clk("dft_test_mode");
    dft_test_mode_i = 1'b0;
  endtask

  task automatic test_random();
    int n, a, b;
    repeat (4) begin
      n = $urandom_range(2, 24);
      handshake(DIV_W'(n));
      wait_idle();
      n_checks++;
      if (clk_div_o !== DIV_W'(n)) begin n_fail++; $display("FAIL rand_value: got %0d required %0d", clk_div_o, n); end
      measure(n, "rand");
    end
    repeat (3) begin
      a = $urandom_range(2, 20);
      b = $urandom_range(2, 20);
      handshake(DIV_W'(a));
      repeat ($urandom_range(0, 8)) step();
      handshake(DIV_W'(b));
      wait_idle();
      repeat (3) step();
      wait_idle();
      n_checks++;
      if (clk_div_o !== DIV_W'(b)) begin n_fail++; $display("FAIL rand_last_wins: got %0d required %0d", clk_div_o, b); end
      measure(b, "rand_b2b");
    end
  endtask

  task automatic test_reset_mid();
    int i, bad;
    handshake(16'd6);
    clk_div_data_i = 16'd3;
    clk_div_valid_i = 1'b1;
    i = 0;
    while (clk_div_ack_o !== 1'b1 && i < 10) begin step(); i++; end
    step();
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b required 1", busy_o); end
    rstn_i = 1'b0;
    clk_div_valid_i = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || clk_div_o !== '0 || clk_div_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: busy=%b div=%0d ack=%b required 0/0/0", busy_o, clk_div_o, clk_div_ack_o);
    end
    repeat (2) step();
    rstn_i = 1'b1;
    bad = 0;
    repeat (30) begin step(); if (busy_o !== 1'b0 || clk_div_o !== '0) bad++; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rmid_no_switch: %0d busy/div samples required 0", bad); end
    check_follows_clk("rmid_bypass");
  endtask

  initial begin
    step();
    test_reset();
    test_div4();
    test_div5_extremes();
    test_queued();
    test_gating();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
